// File: rtl/hit_life_manager.sv
// rtl/hit_life_manager.sv - frame-level lives/score/state sequencer behind the collision detector
module hit_life_manager #(
  parameter int INIT_LIVES     = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int RESPAWN_FRAMES = 30,
  parameter int ENEMY_POINTS   = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       start_game,
  input  logic       coll_player,
  input  logic       coll_enemy1,
  input  logic       coll_enemy2,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       invulnerable,
  output logic       respawn_pulse,
  output logic       enemy1_alive,
  output logic       enemy2_alive,
  output logic [7:0] score,
  output logic       freeze
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DYING = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_LOAD  = 2'(INIT_LIVES);
  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);
  localparam logic [7:0] DYING_LOAD  = 8'(RESPAWN_FRAMES);
  localparam logic [9:0] POINTS      = 10'(ENEMY_POINTS);

  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [7:0] invuln_q, invuln_d;
  logic [7:0] dying_q, dying_d;
  logic       e1_alive_q, e1_alive_d;
  logic       e2_alive_q, e2_alive_d;
  logic       respawn_q, respawn_d;
  logic       p_seen_q, p_seen_d;
  logic       e1_seen_q, e1_seen_d;
  logic       e2_seen_q, e2_seen_d;

  logic       kill1, kill2, hit, last_life;
  logic [9:0] score_sum;
  logic [7:0] score_sat;

  // Frame evaluation terms, all taken from the latches registered before this cycle
  always_comb begin
    kill1     = e1_seen_q & e1_alive_q;
    kill2     = e2_seen_q & e2_alive_q;
    score_sum = {2'b00, score_q} + (kill1 ? POINTS : 10'd0) + (kill2 ? POINTS : 10'd0);
    score_sat = (score_sum > 10'd255) ? 8'hFF : score_sum[7:0];
    hit       = p_seen_q && (invuln_q == 8'd0);
    last_life = hit && (lives_q <= 2'd1);
  end

  // Next-state and next-register logic for the game sequencer
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    invuln_d   = invuln_q;
    dying_d    = dying_q;
    e1_alive_d = e1_alive_q;
    e2_alive_d = e2_alive_q;
    respawn_d  = 1'b0;
    // A collision on the frame strobe itself belongs to the next frame
    p_seen_d   = startOfFrame ? coll_player : (p_seen_q | coll_player);
    e1_seen_d  = startOfFrame ? coll_enemy1 : (e1_seen_q | coll_enemy1);
    e2_seen_d  = startOfFrame ? coll_enemy2 : (e2_seen_q | coll_enemy2);

    case (state_q)
      S_IDLE: begin
        if (start_game) begin
          state_d    = S_PLAY;
          lives_d    = LIVES_LOAD;
          score_d    = 8'd0;
          e1_alive_d = 1'b1;
          e2_alive_d = 1'b1;
          invuln_d   = INVULN_LOAD;
          respawn_d  = 1'b1;
          p_seen_d   = coll_player;
          e1_seen_d  = coll_enemy1;
          e2_seen_d  = coll_enemy2;
        end
      end
      S_PLAY: begin
        if (startOfFrame) begin
          e1_alive_d = e1_alive_q & ~kill1;
          e2_alive_d = e2_alive_q & ~kill2;
          score_d    = score_sat;
          if (hit && lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
          if (last_life) begin
            state_d = S_OVER;
          end else if (!e1_alive_d && !e2_alive_d) begin
            state_d = S_WIN;
          end else if (hit) begin
            state_d = S_DYING;
            dying_d = DYING_LOAD;
          end else if (invuln_q != 8'd0) begin
            invuln_d = invuln_q - 8'd1;
          end
        end
      end
      S_DYING: begin
        if (startOfFrame) begin
          if (dying_q <= 8'd1) begin
            state_d   = S_PLAY;
            dying_d   = 8'd0;
            respawn_d = 1'b1;
            invuln_d  = INVULN_LOAD;
          end else begin
            dying_d = dying_q - 8'd1;
          end
        end
      end
      S_OVER, S_WIN: begin
        if (start_game) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      lives_q    <= LIVES_LOAD;
      score_q    <= 8'd0;
      invuln_q   <= 8'd0;
      dying_q    <= 8'd0;
      e1_alive_q <= 1'b1;
      e2_alive_q <= 1'b1;
      respawn_q  <= 1'b0;
      p_seen_q   <= 1'b0;
      e1_seen_q  <= 1'b0;
      e2_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      invuln_q   <= invuln_d;
      dying_q    <= dying_d;
      e1_alive_q <= e1_alive_d;
      e2_alive_q <= e2_alive_d;
      respawn_q  <= respawn_d;
      p_seen_q   <= p_seen_d;
      e1_seen_q  <= e1_seen_d;
      e2_seen_q  <= e2_seen_d;
    end
  end

  assign state         = state_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign invulnerable  = (invuln_q != 8'd0);
  assign respawn_pulse = respawn_q;
  assign enemy1_alive  = e1_alive_q;
  assign enemy2_alive  = e2_alive_q;
  assign freeze        = (state_q != S_PLAY);

endmodule

// File: tb/tb_hit_life_manager.sv
// tb/tb_hit_life_manager.sv - self-checking bench for hit_life_manager
module tb_hit_life_manager;

  localparam int FL   = 8;
  localparam int INIT = 3;
  localparam int INV  = 60;
  localparam int RSP  = 30;
  localparam int PTS  = 10;
  localparam int PTS2 = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN, sof, start, cp, c1, c2;
  logic [2:0] state, state2;
  logic [1:0] lives, lives2;
  logic inv_o, inv2, rp, rp2, e1a, e1a2, e2a, e2a2, frz, frz2;
  logic [7:0] score, score2;

  int vectors = 0;
  int errors  = 0;

  // reference model: game state kept as plain integers
  int m_state = 0, m_lives = INIT, m_score = 0, m_score2 = 0, m_inv = 0, m_dying = 0;
  bit m_e1 = 1, m_e2 = 1, m_rp = 0, m_ps = 0, m_e1s = 0, m_e2s = 0;

  hit_life_manager dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_game(start),
    .coll_player(cp), .coll_enemy1(c1), .coll_enemy2(c2),
    .state(state), .lives(lives), .invulnerable(inv_o), .respawn_pulse(rp),
    .enemy1_alive(e1a), .enemy2_alive(e2a), .score(score), .freeze(frz)
  );

  hit_life_manager #(.ENEMY_POINTS(PTS2)) dut2 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_game(start),
    .coll_player(cp), .coll_enemy1(c1), .coll_enemy2(c2),
    .state(state2), .lives(lives2), .invulnerable(inv2), .respawn_pulse(rp2),
    .enemy1_alive(e1a2), .enemy2_alive(e2a2), .score(score2), .freeze(frz2)
  );

  task automatic model_step();
    bit ps, e1s, e2s, hit;
    int kills;
    ps = m_ps; e1s = m_e1s; e2s = m_e2s;
    m_rp = 0;
    if (!resetN) begin
      m_state = 0; m_lives = INIT; m_score = 0; m_score2 = 0; m_inv = 0; m_dying = 0;
      m_e1 = 1; m_e2 = 1; m_ps = 0; m_e1s = 0; m_e2s = 0;
      return;
    end
    if (sof || (m_state == 0 && start)) begin
      m_ps = cp; m_e1s = c1; m_e2s = c2;
    end else begin
      m_ps = m_ps | cp; m_e1s = m_e1s | c1; m_e2s = m_e2s | c2;
    end
    case (m_state)
      0: if (start) begin
        m_state = 1; m_lives = INIT; m_score = 0; m_score2 = 0;
        m_e1 = 1; m_e2 = 1; m_inv = INV; m_rp = 1;
      end
      1: if (sof) begin
        kills = 0;
        if (e1s && m_e1) begin m_e1 = 0; kills++; end
        if (e2s && m_e2) begin m_e2 = 0; kills++; end
        m_score  = (m_score  + kills * PTS  > 255) ? 255 : m_score  + kills * PTS;
        m_score2 = (m_score2 + kills * PTS2 > 255) ? 255 : m_score2 + kills * PTS2;
        hit = ps && (m_inv == 0);
        if (hit) m_lives--;
        if (hit && m_lives == 0) m_state = 3;
        else if (!m_e1 && !m_e2) m_state = 4;
        else if (hit) begin m_state = 2; m_dying = RSP; end
        else if (m_inv > 0) m_inv--;
      end
      2: if (sof) begin
        m_dying--;
        if (m_dying == 0) begin m_state = 1; m_rp = 1; m_inv = INV; end
      end
      default: if (start) m_state = 0;
    endcase
  endtask

  task automatic tick(input bit s, input bit st, input bit p, input bit e1, input bit e2);
    sof = s; start = st; cp = p; c1 = e1; c2 = e2;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic frame(input bit p, input bit e1, input bit e2, input int len);
    repeat (len - 1) tick(0, 0, p, e1, e2);
    tick(1, 0, 0, 0, 0);
  endtask

  // play frames until the model reaches PLAY with the target lives and no immunity
  task automatic go_to(input int target);
    int n;
    for (n = 0; n < 1000; n++) begin
      if (m_state == 1 && m_inv == 0 && m_lives == target) break;
      frame(m_state == 1 && m_inv == 0 && m_lives > target, 0, 0, FL);
    end
    vectors++;
    if (n >= 1000) begin
      errors++; $display("FAIL go_to_timeout lives got %0d want %0d", m_lives, target);
    end
  endtask

  task automatic test_reset();
    resetN = 0;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    resetN = 1;
    vectors++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    vectors++; if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives); end
    vectors++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    vectors++; if ({e1a, e2a, inv_o, rp, frz} !== 5'b11001) begin
      errors++; $display("FAIL reset_flags got %b want 11001", {e1a, e2a, inv_o, rp, frz});
    end
  endtask

  task automatic test_start();
    tick(0, 1, 0, 0, 0);
    vectors++; if (state !== 3'd1 || lives !== 2'd3 || score !== 8'd0) begin
      errors++; $display("FAIL start_load got st=%0d l=%0d s=%0d want 1/3/0", state, lives, score);
    end
    vectors++; if ({inv_o, rp, frz} !== 3'b110) begin
      errors++; $display("FAIL start_flags got %b want 110", {inv_o, rp, frz});
    end
    tick(0, 0, 0, 0, 0);
    vectors++; if (rp !== 1'b0) begin errors++; $display("FAIL start_pulse_width got %b want 0", rp); end
  endtask

  task automatic test_invuln();
    for (int f = 1; f <= INV; f++) begin
      frame(1, 0, 0, FL);
      vectors++; if (lives !== 2'd3 || state !== 3'd1) begin
        errors++; $display("FAIL invuln_frame%0d got l=%0d st=%0d want 3/1", f, lives, state);
      end
    end
    frame(1, 0, 0, FL);
    vectors++; if (lives !== 2'd2 || state !== 3'd2 || frz !== 1'b1) begin
      errors++; $display("FAIL first_hit got l=%0d st=%0d want 2/2", lives, state);
    end
    for (int i = 1; i <= RSP; i++) begin
      frame(0, 0, 0, FL);
      if (i < RSP) begin
        vectors++; if (state !== 3'd2 || rp !== 1'b0) begin
          errors++; $display("FAIL dying_hold%0d got st=%0d rp=%b want 2/0", i, state, rp);
        end
      end
    end
    vectors++; if (state !== 3'd1 || rp !== 1'b1 || inv_o !== 1'b1) begin
      errors++; $display("FAIL respawn got st=%0d rp=%b inv=%b want 1/1/1", state, rp, inv_o);
    end
    tick(0, 0, 0, 0, 0);
    vectors++; if (rp !== 1'b0) begin errors++; $display("FAIL respawn_width got %b want 0", rp); end
  endtask

  task automatic test_enemy_kill();
    frame(0, 1, 0, 500);
    vectors++; if (e1a !== 1'b0 || e2a !== 1'b1 || score !== 8'd10) begin
      errors++; $display("FAIL kill1 got e1=%b e2=%b s=%0d want 0/1/10", e1a, e2a, score);
    end
    repeat (3) frame(0, 1, 0, FL);
    vectors++; if (score !== 8'd10) begin errors++; $display("FAIL dead_enemy_score got %0d want 10", score); end
  endtask

  task automatic test_coincident();
    go_to(2);
    vectors++; if (inv_o !== 1'b0) begin errors++; $display("FAIL invuln_expired got %b want 0", inv_o); end
    repeat (FL - 1) tick(0, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    vectors++; if (lives !== 2'd2 || state !== 3'd1) begin
      errors++; $display("FAIL coincident_same got l=%0d st=%0d want 2/1", lives, state);
    end
    frame(0, 0, 0, FL);
    vectors++; if (lives !== 2'd1 || state !== 3'd2) begin
      errors++; $display("FAIL coincident_next got l=%0d st=%0d want 1/2", lives, state);
    end
  endtask

  task automatic test_last_life();
    resetN = 0; tick(0, 0, 0, 0, 0); resetN = 1;
    tick(0, 1, 0, 0, 0);
    go_to(1);
    frame(1, 1, 1, FL);
    vectors++; if (score !== 8'd20 || lives !== 2'd0 || state !== 3'd3) begin
      errors++; $display("FAIL last_life got s=%0d l=%0d st=%0d want 20/0/3", score, lives, state);
    end
    vectors++; if (score2 !== 8'd255) begin errors++; $display("FAIL score_saturate got %0d want 255", score2); end
    tick(0, 1, 0, 0, 0);
    vectors++; if (state !== 3'd0 || score !== 8'd20) begin
      errors++; $display("FAIL over_to_idle got st=%0d s=%0d want 0/20", state, score);
    end
    tick(0, 1, 0, 0, 0);
    go_to(2);
    frame(1, 1, 1, FL);
    vectors++; if (score !== 8'd20 || lives !== 2'd1 || state !== 3'd4 || frz !== 1'b1) begin
      errors++; $display("FAIL win_with_hit got s=%0d l=%0d st=%0d want 20/1/4", score, lives, state);
    end
  endtask

  task automatic test_reset_dying();
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    go_to(3);
    frame(0, 1, 0, FL);
    frame(1, 0, 0, FL);
    vectors++; if (state !== 3'd2 || score !== 8'd10) begin
      errors++; $display("FAIL pre_reset got st=%0d s=%0d want 2/10", state, score);
    end
    resetN = 0; tick(0, 0, 0, 0, 0);
    vectors++; if (state !== 3'd0 || lives !== 2'd3 || score !== 8'd0 || e1a !== 1'b1) begin
      errors++; $display("FAIL reset_in_dying got st=%0d l=%0d s=%0d e1=%b want 0/3/0/1", state, lives, score, e1a);
    end
    resetN = 1;
  endtask

  task automatic test_random();
    logic [16:0] got, exp, got2, exp2;
    int shown = 0;
    for (int i = 0; i < 6000; i++) begin
      resetN = ($urandom_range(0, 1499) != 0);
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0);
      got  = {state, lives, inv_o, rp, e1a, e2a, score, frz};
      got2 = {state2, lives2, inv2, rp2, e1a2, e2a2, score2, frz2};
      exp  = {3'(m_state), 2'(m_lives), m_inv != 0, m_rp, m_e1, m_e2, 8'(m_score), m_state != 1};
      exp2 = {3'(m_state), 2'(m_lives), m_inv != 0, m_rp, m_e1, m_e2, 8'(m_score2), m_state != 1};
      vectors++;
      if (got !== exp || got2 !== exp2) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle%0d got %h/%h want %h/%h", i, got, got2, exp, exp2);
        end
      end
    end
  endtask

  initial begin
    resetN = 0; sof = 0; start = 0; cp = 0; c1 = 0; c2 = 0;
    test_reset();
    test_start();
    test_invuln();
    test_enemy_kill();
    test_coincident();
    test_last_life();
    test_reset_dying();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
